universal_segment_reader: RTL and testbench

Reads a multiplexed 7-segment display bus (segment lines plus one-hot digit strobes) and recovers the BCD/hex code shown on each digit position. It is the receive-side counterpart of the universal BCD-to-7-segment decoder, sitting between display pins and a control or test core. Each strobe window is qualified for stability, inverse-decoded against the selected glyph version, and reported over a valid/ready stream only when a digit's recovered code changes.

---
 rtl/universal_segment_reader.sv | 261 ++++++++++++++++++++++++++
 tb/tb_universal_segment_reader.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/universal_segment_reader.sv
// Receive-side reader for a multiplexed 7-segment bus: qualifies each strobe window,
// inverse-decodes the glyph for the selected version and streams a record when a digit's code changes.
module universal_segment_reader #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3,
    localparam int IW = $clog2(DIGITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              al,
    input  logic              v0,
    input  logic              v1,
    input  logic              v2,
    input  logic              sa,
    input  logic              sb,
    input  logic              sc,
    input  logic              sd,
    input  logic              se,
    input  logic              sf,
    input  logic              sg,
    input  logic [DIGITS-1:0] ds,
    input  logic              ready,
    output logic              valid,
    output logic [IW-1:0]     idx,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              blank,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    state_t            state;
    state_t            state_next;
    logic [6:0]        pin_pat;
    logic [DIGITS-1:0] ds_r;
    logic [6:0]        p_r;
    logic [3:0]        cnt;
    logic [3:0]        cnt_next;
    logic              done;
    logic              done_keep;
    logic              onehot_in;
    logic              change;
    logic [IW-1:0]     idx_r;
    logic [5:0]        dec;
    logic              differ;
    logic              can_load;
    logic              act;
    logic              load_en;
    logic              mark_done;
    logic              seen_st  [DIGITS];
    logic [5:0]        entry_st [DIGITS];

    function automatic logic is_onehot(input logic [DIGITS-1:0] v);
        return (v != '0) && ((v & (v - DIGITS'(1))) == '0);
    endfunction

    // Result is {code[3:0], blank, err}; version-specific glyphs take precedence (hex 7C is 11, not 6).
    function automatic logic [5:0] decode(input logic [2:0] ver, input logic [6:0] p);
        logic [4:0] ext;
        logic [4:0] com;
        ext = 5'h00;
        com = 5'h00;
        case (ver)
            3'd1: case (p)
                7'h58: ext = 5'h1A;
                7'h4C: ext = 5'h1B;
                7'h62: ext = 5'h1C;
                7'h69: ext = 5'h1D;
                7'h78: ext = 5'h1E;
                default: ext = 5'h00;
            endcase
            3'd2: case (p)
                7'h5C: ext = 5'h1A;
                7'h63: ext = 5'h1B;
                7'h01: ext = 5'h1C;
                7'h40: ext = 5'h1D;
                7'h08: ext = 5'h1E;
                default: ext = 5'h00;
            endcase
            3'd4: case (p)
                7'h08: ext = 5'h1A;
                7'h48: ext = 5'h1B;
                7'h49: ext = 5'h1C;
                7'h41: ext = 5'h1D;
                7'h01: ext = 5'h1E;
                default: ext = 5'h00;
            endcase
            3'd5: case (p)
                7'h40: ext = 5'h1A;
                7'h38: ext = 5'h1B;
                7'h39: ext = 5'h1C;
                7'h31: ext = 5'h1D;
                7'h79: ext = 5'h1E;
                default: ext = 5'h00;
            endcase
            3'd6: case (p)
                7'h40: ext = 5'h1A;
                7'h79: ext = 5'h1B;
                7'h76: ext = 5'h1C;
                7'h38: ext = 5'h1D;
                7'h73: ext = 5'h1E;
                default: ext = 5'h00;
            endcase
            3'd7: case (p)
                7'h77: ext = 5'h1A;
                7'h7C: ext = 5'h1B;
                7'h39: ext = 5'h1C;
                7'h5E: ext = 5'h1D;
                7'h79: ext = 5'h1E;
                7'h71: ext = 5'h1F;
                default: ext = 5'h00;
            endcase
            default: ext = 5'h00;
        endcase
        case (p)
            7'h3F:         com = 5'h10;
            7'h06:         com = 5'h11;
            7'h5B:         com = 5'h12;
            7'h4F:         com = 5'h13;
            7'h66:         com = 5'h14;
            7'h6D:         com = 5'h15;
            7'h7D, 7'h7C:  com = 5'h16;
            7'h27, 7'h07:  com = 5'h17;
            7'h7F:         com = 5'h18;
            7'h6F, 7'h67:  com = 5'h19;
            default:       com = 5'h00;
        endcase
        if (p == 7'h00) begin
            case (ver)
                3'd1, 3'd2, 3'd4, 3'd5, 3'd6: return {4'd15, 1'b1, 1'b0};
                default:                      return {4'd0, 1'b1, 1'b0};
            endcase
        end else if (ext[4]) begin
            return {ext[3:0], 2'b00};
        end else if (com[4]) begin
            return {com[3:0], 2'b00};
        end
        return {4'd0, 1'b0, 1'b1};
    endfunction

    assign pin_pat  = {sg, sf, se, sd, sc, sb, sa} ^ {7{~al}};
    assign can_load = !valid || ready;

    // The counter tracks how many identical one-hot samples the input register holds, counting the one being captured.
    always_comb begin
        onehot_in = is_onehot(ds);
        change    = !(onehot_in && (ds == ds_r) && (pin_pat == p_r));
        done_keep = change ? 1'b0 : done;
        if (change) begin
            cnt_next = onehot_in ? 4'd1 : 4'd0;
        end else if (cnt == STABLE_C) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + 4'd1;
        end
    end

    always_comb begin
        idx_r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ds_r[i]) begin
                idx_r = IW'(i);
            end
        end
        dec    = decode({v2, v1, v0}, p_r);
        differ = !seen_st[idx_r] || (entry_st[idx_r] != dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_r <= '0;
            p_r  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            ds_r <= ds;
            p_r  <= pin_pat;
            cnt  <= cnt_next;
            done <= change ? 1'b0 : (mark_done ? 1'b1 : done);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // A pending capture waits in HOLD for the output slot unless its window breaks first.
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: begin
                if ((cnt_next == STABLE_C) && !done_keep) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (differ && !can_load && !change) begin
                    state_next = ST_HOLD;
                end else begin
                    state_next = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (change || !differ || can_load) begin
                    state_next = ST_WAIT;
                end
            end
            default: state_next = ST_WAIT;
        endcase
    end

    always_comb begin
        act       = (state == ST_CAPTURE) || ((state == ST_HOLD) && !change);
        load_en   = act && differ && can_load;
        mark_done = act && (!differ || can_load);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid        <= 1'b0;
            idx          <= '0;
            {d, c, b, a} <= 4'd0;
            blank        <= 1'b0;
            err          <= 1'b0;
        end else if (load_en) begin
            valid        <= 1'b1;
            idx          <= idx_r;
            {d, c, b, a} <= dec[5:2];
            blank        <= dec[1];
            err          <= dec[0];
        end else if (ready) begin
            valid        <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                seen_st[i]  <= 1'b0;
                entry_st[i] <= '0;
            end
        end else if (load_en) begin
            seen_st[idx_r]  <= 1'b1;
            entry_st[idx_r] <= dec;
        end
    end

endmodule

// File: tb/tb_universal_segment_reader.sv
// Bench for universal_segment_reader: directed scenarios with constant expectations,
// then randomized windows scored against a table-driven model of the reader.
module tb_universal_segment_reader;

    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] code;
        logic       blank;
        logic       err;
    } rec_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       al      = 1'b1;
    logic [2:0] ver     = 3'd0;
    logic [3:0] cur_ds  = 4'd0;
    logic [6:0] cur_pat = 7'd0;
    logic       ready   = 1'b1;
    logic       v0, v1, v2;
    logic       sa, sb, sc, sd, se, sf, sg;
    logic       valid;
    logic [1:0] idx;
    logic       a, b, c, d;
    logic       blank;
    logic       err;
    rec_t       got;

    int checks = 0;
    int errors = 0;

    bit         model_on = 1'b0;
    rec_t       exp_q [$];
    bit         m_seen [DIGITS];
    logic [5:0] m_entry [DIGITS];
    logic [3:0] m_prev_ds;
    logic [6:0] m_prev_pat;
    int         m_run;

    logic [6:0] common_pat [13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                    7'h7C, 7'h27, 7'h07, 7'h7F, 7'h6F, 7'h67};
    int common_code [13] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 7, 8, 9, 9};
    logic [6:0] extra_pat [8][6] = '{
        '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
        '{7'h58, 7'h4C, 7'h62, 7'h69, 7'h78, 7'h00},
        '{7'h5C, 7'h63, 7'h01, 7'h40, 7'h08, 7'h00},
        '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00},
        '{7'h08, 7'h48, 7'h49, 7'h41, 7'h01, 7'h00},
        '{7'h40, 7'h38, 7'h39, 7'h31, 7'h79, 7'h00},
        '{7'h40, 7'h79, 7'h76, 7'h38, 7'h73, 7'h00},
        '{7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71}
    };
    int blank_code [8] = '{0, 15, 15, 0, 15, 15, 15, 0};

    assign {v2, v1, v0}                 = ver;
    assign {sg, sf, se, sd, sc, sb, sa} = cur_pat ^ {7{~al}};
    assign got                          = {idx, d, c, b, a, blank, err};

    universal_segment_reader #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .al    (al),
        .v0    (v0),
        .v1    (v1),
        .v2    (v2),
        .sa    (sa),
        .sb    (sb),
        .sc    (sc),
        .sd    (sd),
        .se    (se),
        .sf    (sf),
        .sg    (sg),
        .ds    (cur_ds),
        .ready (ready),
        .valid (valid),
        .idx   (idx),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .blank (blank),
        .err   (err)
    );

    always #5 clk = ~clk;

    function automatic rec_t model_record(input int digit, input logic [2:0] v, input logic [6:0] p);
        rec_t r;
        r = '{idx: 2'(digit), code: 4'd0, blank: 1'b0, err: 1'b0};
        if (p == 7'h00) begin
            r.code  = 4'(blank_code[v]);
            r.blank = 1'b1;
            return r;
        end
        for (int i = 0; i < 6; i++) begin
            if (extra_pat[v][i] == p) begin
                r.code = 4'(10 + i);
                return r;
            end
        end
        for (int i = 0; i < 13; i++) begin
            if (common_pat[i] == p) begin
                r.code = 4'(common_code[i]);
                return r;
            end
        end
        r.err = 1'b1;
        return r;
    endfunction

    // Reference: a digit is captured once its run of identical one-hot samples reaches STABLE.
    initial begin
        forever begin
            @(posedge clk);
            if (model_on) begin
                if (($countones(cur_ds) == 1) && (cur_ds == m_prev_ds) && (cur_pat == m_prev_pat)) begin
                    if (m_run < 1000) m_run++;
                end else begin
                    m_run = ($countones(cur_ds) == 1) ? 1 : 0;
                end
                if (m_run == STABLE) begin
                    int   dig;
                    rec_t r;
                    dig = 0;
                    for (int i = 0; i < DIGITS; i++) if (cur_ds[i]) dig = i;
                    r = model_record(dig, ver, cur_pat);
                    if (!m_seen[dig] || (m_entry[dig] != r[5:0])) begin
                        exp_q.push_back(r);
                        m_seen[dig]  = 1'b1;
                        m_entry[dig] = r[5:0];
                    end
                end
                m_prev_ds  = cur_ds;
                m_prev_pat = cur_pat;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_on && valid && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL random_unexpected: got %h expected no record", got);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("[TB] FAIL random_record: got %h expected %h", got, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle(input int n);
        @(negedge clk);
        cur_ds = 4'd0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic watch(input int n, output int nvalid, output rec_t first);
        nvalid = 0;
        first  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid) begin
                if (nvalid == 0) first = got;
                nvalid++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d expected 0", idx); end
        checks++; if ({d, c, b, a} !== 4'd0) begin errors++; $display("[TB] FAIL reset_code: got %h expected 0", {d, c, b, a}); end
        checks++; if (blank !== 1'b0) begin errors++; $display("[TB] FAIL reset_blank: got %b expected 0", blank); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency;
        @(negedge clk);
        al = 1'b1; ver = 3'd7; ready = 1'b1;
        cur_ds = 4'b0001; cur_pat = 7'h7C;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== (i == 4)) begin
                errors++;
                $display("[TB] FAIL latency_valid_cycle%0d: got %b expected %b", i, valid, (i == 4));
            end
        end
        checks++;
        if (got !== rec_t'({2'd0, 4'd11, 1'b0, 1'b0})) begin
            errors++;
            $display("[TB] FAIL latency_record: got %h expected %h", got, rec_t'({2'd0, 4'd11, 1'b0, 1'b0}));
        end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_single: got %b expected 0", valid); end
        idle(3);
    endtask

    task automatic test_no_repeat;
        int   n;
        rec_t r;
        @(negedge clk);
        cur_ds = 4'b0001; cur_pat = 7'h7C;
        watch(8, n, r);
        checks++; if (n !== 0) begin errors++; $display("[TB] FAIL repeat_suppressed: got %0d records expected 0", n); end
        @(negedge clk);
        cur_pat = 7'h7D;
        watch(8, n, r);
        checks++; if (n !== 1) begin errors++; $display("[TB] FAIL repeat_change_count: got %0d expected 1", n); end
        checks++;
        if (r !== rec_t'({2'd0, 4'd6, 1'b0, 1'b0})) begin
            errors++;
            $display("[TB] FAIL repeat_change_record: got %h expected %h", r, rec_t'({2'd0, 4'd6, 1'b0, 1'b0}));
        end
        idle(3);
    endtask

    task automatic test_blank;
        int   n;
        rec_t r;
        @(negedge clk);
        al = 1'b0; ver = 3'd2; cur_ds = 4'b0100; cur_pat = 7'h00;
        watch(8, n, r);
        checks++;
        if ((n !== 1) || (r !== rec_t'({2'd2, 4'd15, 1'b1, 1'b0}))) begin
            errors++;
            $display("[TB] FAIL blank_natsemi: got %0d records first %h expected 1 of %h", n, r, rec_t'({2'd2, 4'd15, 1'b1, 1'b0}));
        end
        idle(3);
        @(negedge clk);
        ver = 3'd0; cur_ds = 4'b1000; cur_pat = 7'h00;
        watch(8, n, r);
        checks++;
        if ((n !== 1) || (r !== rec_t'({2'd3, 4'd0, 1'b1, 1'b0}))) begin
            errors++;
            $display("[TB] FAIL blank_rca: got %0d records first %h expected 1 of %h", n, r, rec_t'({2'd3, 4'd0, 1'b1, 1'b0}));
        end
        idle(3);
    endtask

    task automatic test_toggle_and_error;
        int   n;
        int   total;
        rec_t r;
        total = 0;
        @(negedge clk);
        al = 1'b1; ver = 3'd1; cur_ds = 4'b0010;
        for (int i = 0; i < 12; i++) begin
            cur_pat = i[0] ? 7'h5B : 7'h06;
            watch(2, n, r);
            total += n;
        end
        checks++; if (total !== 0) begin errors++; $display("[TB] FAIL toggle_no_record: got %0d expected 0", total); end
        cur_pat = 7'h12;
        watch(8, n, r);
        checks++;
        if ((n !== 1) || (r !== rec_t'({2'd1, 4'd0, 1'b0, 1'b1}))) begin
            errors++;
            $display("[TB] FAIL error_pattern: got %0d records first %h expected 1 of %h", n, r, rec_t'({2'd1, 4'd0, 1'b0, 1'b1}));
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        int   bad;
        int   n;
        rec_t r;
        bad = 0;
        @(negedge clk);
        ready = 1'b0; ver = 3'd7; al = 1'b1;
        cur_ds = 4'b0001; cur_pat = 7'h3F;
        repeat (4) @(negedge clk);
        checks++;
        if ((valid !== 1'b1) || (got !== rec_t'({2'd0, 4'd0, 1'b0, 1'b0}))) begin
            errors++;
            $display("[TB] FAIL backpressure_first: got valid %b record %h expected 1 %h", valid, got, rec_t'({2'd0, 4'd0, 1'b0, 1'b0}));
        end
        @(negedge clk);
        cur_ds = 4'b0010; cur_pat = 7'h5E;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ((valid !== 1'b1) || (got !== rec_t'({2'd0, 4'd0, 1'b0, 1'b0}))) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL backpressure_hold: got %0d unstable cycles expected 0", bad); end
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if ((valid !== 1'b1) || (got !== rec_t'({2'd1, 4'd13, 1'b0, 1'b0}))) begin
            errors++;
            $display("[TB] FAIL backpressure_second: got valid %b record %h expected 1 %h", valid, got, rec_t'({2'd1, 4'd13, 1'b0, 1'b0}));
        end
        watch(7, n, r);
        checks++; if (n !== 0) begin errors++; $display("[TB] FAIL backpressure_duplicate: got %0d records expected 0", n); end
        idle(3);
    endtask

    task automatic test_reset_mid_record;
        int   n;
        rec_t r;
        @(negedge clk);
        ready = 1'b0; cur_ds = 4'b0100; cur_pat = 7'h4F;
        repeat (4) @(negedge clk);
        checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre_valid: got %b expected 1", valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_async_valid: got %b expected 0", valid); end
        @(negedge clk);
        cur_ds = 4'd0;
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            cur_ds = 4'(1 << i); cur_pat = 7'h06;
            watch(7, n, r);
            checks++;
            if ((n !== 1) || (r !== rec_t'({2'(i), 4'd1, 1'b0, 1'b0}))) begin
                errors++;
                $display("[TB] FAIL midreset_first_capture_digit%0d: got %0d records first %h expected 1 of %h", i, n, r, rec_t'({2'(i), 4'd1, 1'b0, 1'b0}));
            end
            idle(2);
        end
    endtask

    task automatic test_random;
        int sel;
        int len;
        @(negedge clk);
        rst_n = 1'b0; cur_ds = 4'd0; ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < DIGITS; i++) begin
            m_seen[i]  = 1'b0;
            m_entry[i] = '0;
        end
        m_prev_ds = '0; m_prev_pat = '0; m_run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_on = 1'b1;
        for (int batch = 0; batch < 6; batch++) begin
            @(negedge clk);
            ver = 3'($urandom_range(0, 7));
            al  = 1'($urandom_range(0, 1));
            repeat (3) @(negedge clk);
            for (int w = 0; w < 25; w++) begin
                sel = $urandom_range(0, 9);
                if (sel < 8)       cur_ds = 4'(1 << $urandom_range(0, 3));
                else if (sel == 8) cur_ds = 4'd0;
                else               cur_ds = 4'($urandom_range(0, 15));
                sel = $urandom_range(0, 9);
                if (sel == 0)      cur_pat = 7'h00;
                else if (sel < 6)  cur_pat = common_pat[$urandom_range(0, 12)];
                else if (sel < 8)  cur_pat = extra_pat[ver][$urandom_range(0, 5)];
                else               cur_pat = 7'($urandom);
                len = $urandom_range(1, 6);
                repeat (len) @(negedge clk);
            end
            idle(8);
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("[TB] FAIL random_missing_batch%0d: got %0d records outstanding expected 0", batch, exp_q.size());
            end
            exp_q.delete();
        end
        model_on = 1'b0;
    endtask

    initial begin
        $display("[TB] starting universal_segment_reader bench");
        test_reset();
        test_latency();
        test_no_repeat();
        test_blank();
        test_toggle_and_error();
        test_back_to_back();
        test_reset_mid_record();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
